// File: rtl/uart_framer_if.sv
// Control-side bundle of the UART framer: received frame with status pulses,
// and the response frame with its start/busy/done handshake.
`timescale 1ns/1ps
interface uart_framer_if #(
    parameter int RX_BYTES = 2,
    parameter int TX_BYTES = 3
) ();
    logic [8*RX_BYTES-1:0] rxFrame;
    logic                  rxValid;
    logic [1:0]            rxErr;
    logic                  rxErrValid;
    logic [8*TX_BYTES-1:0] txFrame;
    logic                  txStart;
    logic                  txBusy;
    logic                  txDone;

    modport master (
        input  rxFrame, rxValid, rxErr, rxErrValid, txBusy, txDone,
        output txFrame, txStart
    );
    modport slave (
        output rxFrame, rxValid, rxErr, rxErrValid, txBusy, txDone,
        input  txFrame, txStart
    );
endinterface

// File: rtl/uart_framer.sv
// Fixed-length multi-byte UART framer: 16x-oversampled receiver with frame
// assembly and error reporting, plus a back-to-back multi-byte transmitter.
`timescale 1ns/1ps
module uart_framer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int RX_BYTES     = 2,
    parameter int TX_BYTES     = 3,
    parameter int PARITY       = 0,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         serialIn,
    output logic         serialOut,
    uart_framer_if.slave bus
);

    localparam int DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W     = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
    localparam int RXI_W    = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
    localparam int TXI_W    = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;

    localparam logic [1:0] ERR_FRAME   = 2'b01;
    localparam logic [1:0] ERR_PARITY  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic parity_bit(input logic [7:0] d);
        return (^d) ^ (PARITY == 2);
    endfunction

    // ---------------- receiver ----------------
    state_t                rx_state_q;
    logic                  sync1_q, sync2_q;
    logic [DIV_W-1:0]      rx_div_q;
    logic [OS_W-1:0]       rx_os_q;
    logic [2:0]            rx_bit_q;
    logic [7:0]            rx_shift_q;
    logic                  rx_par_q;
    logic [RXI_W-1:0]      rx_idx_q;
    logic [TO_W-1:0]       rx_idle_q;
    logic [8*RX_BYTES-1:0] rx_buf_q, rx_buf_d;
    logic [8*RX_BYTES-1:0] rxFrame_q;
    logic                  rxValid_q;
    logic [1:0]            rxErr_q;
    logic                  rxErrValid_q;

    logic rx_tick, rx_mid, rx_end;
    assign rx_tick = (rx_div_q == DIV_W'(DIV - 1));
    assign rx_mid  = rx_tick && (rx_os_q == OS_W'(OVERSAMPLE/2 - 1));
    assign rx_end  = rx_tick && (rx_os_q == OS_W'(OVERSAMPLE - 1));

    always_comb begin
        rx_buf_d                   = rx_buf_q;
        rx_buf_d[8*rx_idx_q +: 8]  = rx_shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_state_q   <= S_IDLE;
            rx_div_q     <= '0;
            rx_os_q      <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_idx_q     <= '0;
            rx_idle_q    <= '0;
            rx_buf_q     <= '0;
            rxFrame_q    <= '0;
            rxValid_q    <= 1'b0;
            rxErr_q      <= 2'b00;
            rxErrValid_q <= 1'b0;
        end else begin
            sync1_q      <= serialIn;
            sync2_q      <= sync1_q;
            rxValid_q    <= 1'b0;
            rxErrValid_q <= 1'b0;
            rx_div_q     <= rx_tick ? '0 : rx_div_q + 1'b1;
            if (rx_tick)
                rx_os_q <= rx_end ? '0 : rx_os_q + 1'b1;

            case (rx_state_q)
                S_IDLE: begin
                    if (!sync2_q) begin
                        rx_state_q <= S_START;
                        rx_div_q   <= '0;
                        rx_os_q    <= '0;
                        rx_idle_q  <= '0;
                    end else if (rx_idx_q != '0 && rx_tick) begin
                        // A stalled partial frame is dropped after a quiet period.
                        if (rx_idle_q == TO_W'(TO_TICKS - 1)) begin
                            rx_idle_q    <= '0;
                            rx_idx_q     <= '0;
                            rxErr_q      <= ERR_TIMEOUT;
                            rxErrValid_q <= 1'b1;
                        end else begin
                            rx_idle_q <= rx_idle_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (rx_mid) begin
                        rx_os_q <= '0;
                        if (!sync2_q) begin
                            rx_state_q <= S_DATA;
                            rx_bit_q   <= '0;
                        end else begin
                            rx_state_q <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_end) begin
                        rx_shift_q <= {sync2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7)
                            rx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (rx_end) begin
                        rx_par_q   <= sync2_q;
                        rx_state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (rx_end) begin
                        rx_state_q <= S_IDLE;
                        if (!sync2_q || (PARITY != 0 && rx_par_q != parity_bit(rx_shift_q))) begin
                            rxErr_q      <= !sync2_q ? ERR_FRAME : ERR_PARITY;
                            rxErrValid_q <= 1'b1;
                            rx_idx_q     <= '0;
                        end else if (rx_idx_q == RXI_W'(RX_BYTES - 1)) begin
                            rxFrame_q <= rx_buf_d;
                            rxValid_q <= 1'b1;
                            rx_idx_q  <= '0;
                        end else begin
                            rx_buf_q <= rx_buf_d;
                            rx_idx_q <= rx_idx_q + 1'b1;
                        end
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    state_t                tx_state_q;
    logic [DIV_W-1:0]      tx_div_q;
    logic [OS_W-1:0]       tx_os_q;
    logic [2:0]            tx_bit_q;
    logic [TXI_W-1:0]      tx_idx_q;
    logic [8*TX_BYTES-1:0] tx_frame_q;
    logic                  serialOut_q;
    logic                  txBusy_q;
    logic                  txDone_q;

    logic       tx_tick, tx_end;
    logic [7:0] tx_byte;
    assign tx_tick = (tx_div_q == DIV_W'(DIV - 1));
    assign tx_end  = tx_tick && (tx_os_q == OS_W'(OVERSAMPLE - 1));
    assign tx_byte = tx_frame_q[8*tx_idx_q +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= S_IDLE;
            tx_div_q    <= '0;
            tx_os_q     <= '0;
            tx_bit_q    <= '0;
            tx_idx_q    <= '0;
            tx_frame_q  <= '0;
            serialOut_q <= 1'b1;
            txBusy_q    <= 1'b0;
            txDone_q    <= 1'b0;
        end else begin
            txDone_q <= 1'b0;
            if (tx_state_q != S_IDLE) begin
                tx_div_q <= tx_tick ? '0 : tx_div_q + 1'b1;
                if (tx_tick)
                    tx_os_q <= tx_end ? '0 : tx_os_q + 1'b1;
            end

            case (tx_state_q)
                S_IDLE: begin
                    if (bus.txStart) begin
                        tx_frame_q  <= bus.txFrame;
                        tx_state_q  <= S_START;
                        tx_div_q    <= '0;
                        tx_os_q     <= '0;
                        tx_idx_q    <= '0;
                        serialOut_q <= 1'b0;
                        txBusy_q    <= 1'b1;
                    end
                end
                S_START: begin
                    if (tx_end) begin
                        tx_state_q  <= S_DATA;
                        tx_bit_q    <= '0;
                        serialOut_q <= tx_byte[0];
                    end
                end
                S_DATA: begin
                    if (tx_end) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q  <= (PARITY != 0) ? S_PARITY : S_STOP;
                            serialOut_q <= (PARITY != 0) ? parity_bit(tx_byte) : 1'b1;
                        end else begin
                            tx_bit_q    <= tx_bit_q + 1'b1;
                            serialOut_q <= tx_byte[tx_bit_q + 3'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tx_end) begin
                        tx_state_q  <= S_STOP;
                        serialOut_q <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_end) begin
                        // Next byte's start bit follows the stop bit with no gap.
                        if (tx_idx_q == TXI_W'(TX_BYTES - 1)) begin
                            tx_state_q <= S_IDLE;
                            txBusy_q   <= 1'b0;
                            txDone_q   <= 1'b1;
                        end else begin
                            tx_idx_q    <= tx_idx_q + 1'b1;
                            tx_state_q  <= S_START;
                            serialOut_q <= 1'b0;
                        end
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    assign serialOut      = serialOut_q;
    assign bus.rxFrame    = rxFrame_q;
    assign bus.rxValid    = rxValid_q;
    assign bus.rxErr      = rxErr_q;
    assign bus.rxErrValid = rxErrValid_q;
    assign bus.txBusy     = txBusy_q;
    assign bus.txDone     = txDone_q;

endmodule

// File: tb/tb_uart_framer.sv
// Bench for uart_framer: a no-parity instance driven directly and an
// even-parity instance with its TX looped back into its RX.
`timescale 1ns/1ps
module tb_uart_framer;

    localparam int BIT = 160;

    logic clk;
    logic rst_n;
    logic serial_in0, serial_out0;
    logic serial_in1, serial_out1;
    logic flip1;

    uart_framer_if #(.RX_BYTES(2), .TX_BYTES(3)) if0 ();
    uart_framer_if #(.RX_BYTES(3), .TX_BYTES(3)) if1 ();

    uart_framer #(
        .CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
        .RX_BYTES(2), .TX_BYTES(3), .PARITY(0), .TIMEOUT_BITS(20)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .serialIn(serial_in0), .serialOut(serial_out0), .bus(if0)
    );

    uart_framer #(
        .CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
        .RX_BYTES(3), .TX_BYTES(3), .PARITY(1), .TIMEOUT_BITS(20)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .serialIn(serial_in1), .serialOut(serial_out1), .bus(if1)
    );

    assign serial_in1 = serial_out1 ^ flip1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int rv0 = 0, erv0 = 0, rv1 = 0, erv1 = 0;

    always @(negedge clk) begin
        if (if0.rxValid)    rv0++;
        if (if0.rxErrValid) erv0++;
        if (if1.rxValid)    rv1++;
        if (if1.rxErrValid) erv1++;
    end

    initial begin
        #(10 * 120_000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle0(input int n);
        serial_in0 = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int per, input int stop_low);
        serial_in0 = 1'b0;
        repeat (per) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in0 = b[i];
            repeat (per) @(posedge clk);
        end
        if (stop_low > 0) begin
            serial_in0 = 1'b0;
            repeat (stop_low) @(posedge clk);
            serial_in0 = 1'b1;
            repeat (per - stop_low) @(posedge clk);
        end else begin
            serial_in0 = 1'b1;
            repeat (per) @(posedge clk);
        end
    endtask

    // Launch a frame on the looped-back instance; optionally corrupt byte 0's
    // parity bit (bit slot 9) on the wire. Returns clks from accept to txDone.
    task automatic tx1(input logic [23:0] f, input bit flip_par, output int c);
        @(negedge clk);
        if1.txFrame = f;
        if1.txStart = 1'b1;
        @(posedge clk);
        #1 if1.txStart = 1'b0;
        c = 0;
        while (c < 6000 && !if1.txDone) begin
            @(posedge clk);
            #1;
            c++;
            flip1 = flip_par && (c >= 9*BIT + 30) && (c < 9*BIT + 130);
        end
        flip1 = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          per;
        logic [15:0] exp;
    } rxvec_t;

    rxvec_t vecs[4];

    initial begin
        int r, e, c;
        logic [23:0] txf;
        logic [29:0] txexp;

        vecs[0] = '{8'h01, 8'hA5, 160, 16'hA501};
        vecs[1] = '{8'h00, 8'hFF, 160, 16'hFF00};
        vecs[2] = '{8'h55, 8'hC3, 163, 16'hC355};
        vecs[3] = '{8'h80, 8'h7E, 157, 16'h7E80};

        rst_n = 1'b0;
        serial_in0 = 1'b1;
        flip1 = 1'b0;
        if0.txStart = 1'b0;
        if0.txFrame = '0;
        if1.txStart = 1'b0;
        if1.txFrame = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_serialOut", 32'(serial_out0), 32'd1);
        chk("rst_rxFrame", 32'(if0.rxFrame), 32'h0);
        chk("rst_rxValid", 32'(if0.rxValid), 32'd0);
        chk("rst_rxErr", 32'(if0.rxErr), 32'd0);
        chk("rst_rxErrValid", 32'(if0.rxErrValid), 32'd0);
        chk("rst_txBusy", 32'(if0.txBusy), 32'd0);
        chk("rst_txDone", 32'(if0.txDone), 32'd0);
        rst_n = 1'b1;
        idle0(3 * BIT);

        // Clean two-byte frames, including +/-2% line-rate error.
        for (int k = 0; k < 4; k++) begin
            r = rv0;
            e = erv0;
            send_byte(vecs[k].b0, vecs[k].per, 0);
            send_byte(vecs[k].b1, vecs[k].per, 0);
            idle0(2 * BIT);
            @(negedge clk);
            chk($sformatf("frame%0d_data", k), 32'(if0.rxFrame), 32'(vecs[k].exp));
            chk($sformatf("frame%0d_rxValid_count", k), 32'(rv0 - r), 32'd1);
            chk($sformatf("frame%0d_no_err", k), 32'(erv0 - e), 32'd0);
        end

        // Framing error on the second byte discards the partial frame.
        r = rv0;
        e = erv0;
        send_byte(8'h01, BIT, 0);
        send_byte(8'h33, BIT, 110);
        idle0(3 * BIT);
        @(negedge clk);
        chk("framing_code", 32'(if0.rxErr), 32'd1);
        chk("framing_errValid_count", 32'(erv0 - e), 32'd1);
        chk("framing_no_rxValid", 32'(rv0 - r), 32'd0);
        chk("framing_frame_held", 32'(if0.rxFrame), 32'h7E80);
        send_byte(8'h02, BIT, 0);
        send_byte(8'h04, BIT, 0);
        idle0(2 * BIT);
        @(negedge clk);
        chk("after_framing_data", 32'(if0.rxFrame), 32'h0402);
        chk("after_framing_rxValid_count", 32'(rv0 - r), 32'd1);

        // Short low glitch on an idle line is a false start.
        r = rv0;
        e = erv0;
        serial_in0 = 1'b0;
        repeat (40) @(posedge clk);
        idle0(3 * BIT);
        @(negedge clk);
        chk("glitch_no_rxValid", 32'(rv0 - r), 32'd0);
        chk("glitch_no_err", 32'(erv0 - e), 32'd0);
        chk("glitch_frame_held", 32'(if0.rxFrame), 32'h0402);

        // Partial frame left idle for 20 bit periods times out.
        r = rv0;
        e = erv0;
        send_byte(8'h07, BIT, 0);
        idle0(22 * BIT);
        @(negedge clk);
        chk("timeout_code", 32'(if0.rxErr), 32'd3);
        chk("timeout_errValid_count", 32'(erv0 - e), 32'd1);
        chk("timeout_no_rxValid", 32'(rv0 - r), 32'd0);
        send_byte(8'h09, BIT, 0);
        send_byte(8'h0A, BIT, 0);
        idle0(2 * BIT);
        @(negedge clk);
        chk("after_timeout_data", 32'(if0.rxFrame), 32'h0A09);
        chk("after_timeout_rxValid_count", 32'(rv0 - r), 32'd1);
        chk("after_timeout_single_err", 32'(erv0 - e), 32'd1);

        // Transmit 01,0F,3C; a second start at clk 100 with new data is ignored.
        txf = 24'h3C0F01;
        for (int k = 0; k < 3; k++) begin
            txexp[10*k] = 1'b0;
            for (int i = 0; i < 8; i++) txexp[10*k + 1 + i] = txf[8*k + i];
            txexp[10*k + 9] = 1'b1;
        end
        @(negedge clk);
        if0.txFrame = txf;
        if0.txStart = 1'b1;
        @(posedge clk);
        #1 if0.txStart = 1'b0;
        for (int cc = 1; cc <= 4900; cc++) begin
            @(posedge clk);
            #1;
            if (cc == 99) begin
                if0.txFrame = 24'hFFFFFF;
                if0.txStart = 1'b1;
            end
            if (cc == 100) if0.txStart = 1'b0;
            if (cc == 1) chk("tx_busy_start", 32'(if0.txBusy), 32'd1);
            if (cc % BIT == 80 && cc < 30 * BIT)
                chk($sformatf("tx_bit%0d", cc / BIT), 32'(serial_out0), 32'(txexp[cc / BIT]));
            if (cc == 4799) begin
                chk("tx_busy_before_end", 32'(if0.txBusy), 32'd1);
                chk("tx_done_not_early", 32'(if0.txDone), 32'd0);
            end
            if (cc == 4800) begin
                chk("tx_done_at_4800", 32'(if0.txDone), 32'd1);
                chk("tx_busy_clear", 32'(if0.txBusy), 32'd0);
            end
            if (cc == 4801) chk("tx_done_one_clk", 32'(if0.txDone), 32'd0);
            if (cc == 4900) begin
                chk("tx_no_second_frame_busy", 32'(if0.txBusy), 32'd0);
                chk("tx_no_second_frame_line", 32'(serial_out0), 32'd1);
            end
        end

        // Even-parity loopback: clean frame, then a corrupted parity bit.
        r = rv1;
        e = erv1;
        tx1(24'h9D42E7, 1'b0, c);
        chk("lb_done_clk", 32'(c), 32'd5280);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("lb_frame", 32'(if1.rxFrame), 32'h9D42E7);
        chk("lb_rxValid_count", 32'(rv1 - r), 32'd1);
        chk("lb_no_err", 32'(erv1 - e), 32'd0);

        r = rv1;
        e = erv1;
        tx1(24'h1234F0, 1'b1, c);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("parity_code", 32'(if1.rxErr), 32'd2);
        chk("parity_errValid_count", 32'(erv1 - e), 32'd1);
        chk("parity_no_rxValid", 32'(rv1 - r), 32'd0);
        chk("parity_frame_held", 32'(if1.rxFrame), 32'h9D42E7);
        repeat (22 * BIT) @(posedge clk);
        @(negedge clk);
        chk("parity_tail_timeout", 32'(if1.rxErr), 32'd3);

        // Reset during a transmission releases the line at once.
        @(negedge clk);
        if1.txFrame = 24'hAAAAAA;
        if1.txStart = 1'b1;
        @(posedge clk);
        #1 if1.txStart = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        chk("midtx_line_low", 32'(serial_out1), 32'd0);
        chk("midtx_busy", 32'(if1.txBusy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_line_high", 32'(serial_out1), 32'd1);
        chk("reset_busy_clear", 32'(if1.txBusy), 32'd0);
        chk("reset_rxFrame_clear", 32'(if1.rxFrame), 32'h0);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
